// File: rtl/interface_pkg.sv
// Shared types and helpers for the operand request/response channel.
package interface_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  localparam int unsigned StatsWidth = 16;
  localparam int unsigned MaxWidth   = 64;

  // Operates at MaxWidth; callers keep the low bits of their own width. Carries and
  // borrows only move upward, so the truncated result is exact modulo 2^width.
  function automatic logic [MaxWidth-1:0] calc_c(input op_t                 op,
                                                 input logic [MaxWidth-1:0] a,
                                                 input logic [MaxWidth-1:0] b);
    logic [MaxWidth-1:0] c;
    unique case (op)
      OP_ADD:  c = a + b;
      OP_SUB:  c = a - b;
      OP_AND:  c = a & b;
      OP_XOR:  c = a ^ b;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/interface_sync_fifo.sv
// First-word fall-through synchronous FIFO with a count register; read data is zero when empty.
module interface_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers are exactly log2(Depth) bits, so increments wrap on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/interface_responder.sv
// Responder end of the operand channel: one compute stage feeding a response FIFO.
// Optional response counter port enabled by INTERFACE_RESPONDER_STATS_EN.
module interface_responder
  import interface_pkg::*;
#(
  parameter int unsigned ParamA = 8,
  parameter int unsigned Depth  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ParamA-1:0]     i_req_a,
  input  logic [ParamA-1:0]     i_req_b,
  input  logic [1:0]            i_req_op,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
`ifdef INTERFACE_RESPONDER_STATS_EN
  output logic [StatsWidth-1:0] o_rsp_count,
`endif
  output logic [ParamA-1:0]     o_rsp_c
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic                req_fire, rsp_fire;
  logic                stage_valid_q;
  logic [ParamA-1:0]   stage_c_q;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic                req_ready_q;
  logic                fifo_empty, fifo_full;
  logic [CntW-1:0]     fifo_count;
  logic [MaxWidth-1:0] a_ext, b_ext, c_ext;

  assign req_fire    = i_req_valid && req_ready_q;
  assign rsp_fire    = o_rsp_valid && i_rsp_ready;
  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = !fifo_empty;

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[ParamA-1:0] = i_req_a;
    b_ext[ParamA-1:0] = i_req_b;
    c_ext = calc_c(op_t'(i_req_op), a_ext, b_ext);
  end

  if (ParamA < MaxWidth) begin : g_c_hi
    logic unused_c_hi;
    assign unused_c_hi = ^c_ext[MaxWidth-1:ParamA];
  end

  // Stage plus FIFO occupancy; ready comes from a register so i_rsp_ready never reaches it.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({req_fire, rsp_fire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_valid_q <= 1'b0;
      stage_c_q     <= '0;
      inflight_q    <= '0;
      req_ready_q   <= 1'b1;
    end else begin
      stage_valid_q <= req_fire;
      if (req_fire) stage_c_q <= c_ext[ParamA-1:0];
      inflight_q    <= inflight_d;
      req_ready_q   <= (inflight_d < CntW'(Depth));
    end
  end

  interface_sync_fifo #(
    .Width (ParamA),
    .Depth (Depth)
  ) u_rsp_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (stage_valid_q && !fifo_full),
    .pop_i   (rsp_fire),
    .wdata_i (stage_c_q),
    .rdata_o (o_rsp_c),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;

`ifdef INTERFACE_RESPONDER_STATS_EN
  logic [StatsWidth-1:0] rsp_count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_count_q <= '0;
    end else if (rsp_fire) begin
      rsp_count_q <= rsp_count_q + 1'b1;
    end
  end

  assign o_rsp_count = rsp_count_q;
`endif

endmodule

// File: tb/tb_interface_responder.sv
// Directed bench for interface_responder with a queue-based reference model checked every cycle.
module tb_interface_responder;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a, req_b;
  logic [1:0] req_op;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_c;
`ifdef INTERFACE_RESPONDER_STATS_EN
  logic [15:0] rsp_count;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  interface_responder #(
    .ParamA (8),
    .Depth  (Depth)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_op    (req_op),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
`ifdef INTERFACE_RESPONDER_STATS_EN
    .o_rsp_count (rsp_count),
`endif
    .o_rsp_c     (rsp_c)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Reference model: every accepted request becomes a queue entry visible two edges later.
  typedef struct {
    logic [7:0] c;
    int         avail;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   m_count = 0;

  initial forever begin
    bit   v;
    bit   r;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_count = 0;
    end else begin
      v = (q.size() > 0) && (q[0].avail <= cyc);
      r = (q.size() < Depth);
      if (v && rsp_ready) begin
        void'(q.pop_front());
        m_count = (m_count + 1) % 65536;
      end
      if (r && req_valid) begin
        e.c     = ref_op(req_op, req_a, req_b);
        e.avail = cyc + 2;
        q.push_back(e);
      end
    end
    cyc++;
  end

  initial forever begin
    bit mv;
    @(negedge clk);
    if (chk_en) begin
      mv = (q.size() > 0) && (q[0].avail <= cyc);
      check("model_ready", req_ready, (q.size() < Depth));
      check("model_valid", rsp_valid, mv);
      if (mv) check("model_data", rsp_c, q[0].c);
`ifdef INTERFACE_RESPONDER_STATS_EN
      check("model_count", rsp_count, m_count);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the edge that accepts it; leaves valid high.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    bit acc;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    for (int i = 0; i < 20; i++) begin
      acc = req_ready;
      tick();
      if (acc) return;
    end
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_xor [4];
    exp_xor[0] = 8'h2D;
    exp_xor[1] = 8'h2E;
    exp_xor[2] = 8'h2F;
    exp_xor[3] = 8'h28;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", req_ready, 1'b1);
    check("reset_valid", rsp_valid, 1'b0);
    check("reset_c", rsp_c, 8'h00);
    chk_en = 1'b1;
    tick();

    // Single requests, two-cycle latency
    rsp_ready = 1'b1;
    send(8'hF0, 8'h20, 2'd0);
    req_valid = 1'b0;
    check("add_lat1_valid", rsp_valid, 1'b0);
    tick();
    check("add_lat2_valid", rsp_valid, 1'b1);
    check("add_c", rsp_c, 8'h10);
    tick();
    check("add_popped", rsp_valid, 1'b0);
    send(8'h01, 8'h02, 2'd1);
    req_valid = 1'b0;
    tick();
    check("sub_valid", rsp_valid, 1'b1);
    check("sub_c", rsp_c, 8'hFF);
    tick();

    // Fill to Depth with the consumer stalled
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 8'h3C, 2'd3);
    check("full_ready", req_ready, 1'b0);
    req_a = 8'h14; req_b = 8'h3C; req_op = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_ready", req_ready, 1'b0);
      check("held_valid", rsp_valid, 1'b1);
      check("held_c", rsp_c, 8'h2C);
    end

    // Single pop from full; ready returns only after the pop edge
    rsp_ready = 1'b1;
    check("pop_cycle_ready", req_ready, 1'b0);
    tick();
    rsp_ready = 1'b0;
    check("ready_reassert", req_ready, 1'b1);
    check("after_pop_c", rsp_c, 8'h2D);
    tick();
    req_valid = 1'b0;
    check("refull_ready", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("drain_valid", rsp_valid, 1'b1);
      check("drain_c", rsp_c, exp_xor[j]);
      tick();
    end
    check("drained_valid", rsp_valid, 1'b0);

    // Streaming: one acceptance per cycle, pointers wrap repeatedly
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1;
      req_a     = 8'(i * 13 + 7);
      req_b     = 8'hB6;
      req_op    = 2'd2;
      check("stream_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    repeat (3) tick();
    check("stream_done_valid", rsp_valid, 1'b0);
`ifdef INTERFACE_RESPONDER_STATS_EN
    check("stream_count", rsp_count, 16'd20);
`endif

    // Reset with three results buffered
    rsp_ready = 1'b0;
    send(8'h01, 8'h01, 2'd0);
    send(8'h02, 8'h02, 2'd0);
    send(8'h03, 8'h03, 2'd0);
    req_valid = 1'b0;
    tick();
    tick();
    check("buffered_valid", rsp_valid, 1'b1);
    check("buffered_c", rsp_c, 8'h02);
    rst = 1'b1;
    tick();
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_c", rsp_c, 8'h00);
`ifdef INTERFACE_RESPONDER_STATS_EN
    check("midrst_count", rsp_count, 16'd0);
`endif
    rst = 1'b0;
    rsp_ready = 1'b1;
    send(8'h05, 8'h03, 2'd0);
    req_valid = 1'b0;
    check("post_rst_lat1", rsp_valid, 1'b0);
    tick();
    check("post_rst_valid", rsp_valid, 1'b1);
    check("post_rst_c", rsp_c, 8'h08);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
